// File: rtl/corr_tap_bank.sv
// Multi-tap 1-bit code correlator: one code NCO, TAPS phase-shifted replicas, signed
// accumulate-and-dump per tap into a valid/ready output register. Optional CORR_DISC_EN adds disc.

module corr_tap_lane #(
    parameter int PHASE_W = 16,
    parameter int ACC_W   = 16
) (
    input  logic               clk,
    input  logic               rst_in,
    input  logic [PHASE_W-1:0] phase_i,
    input  logic [PHASE_W-1:0] offset_i,
    input  logic               sig_i,
    input  logic               accept_i,
    input  logic               restart_i,
    output logic [ACC_W-1:0]   sum_o
);
    logic             replica;
    logic             match;
    logic [ACC_W-1:0] acc_q, acc_d;

    // MSB of (phase - offset): operand MSBs xor the borrow out of the low bits.
    assign replica = phase_i[PHASE_W-1] ^ offset_i[PHASE_W-1]
                   ^ (phase_i[PHASE_W-2:0] < offset_i[PHASE_W-2:0]);
    assign match   = (sig_i == replica);

    // Running sum including the current sample; this is what a dump captures.
    assign sum_o = acc_q + (match ? ACC_W'(1) : {ACC_W{1'b1}});

    always_comb begin
        acc_d = acc_q;
        if (restart_i)
            acc_d = '0;
        else if (accept_i)
            acc_d = sum_o;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) acc_q <= '0;
        else        acc_q <= acc_d;
    end
endmodule

module corr_tap_bank #(
    parameter int TAPS    = 3,
    parameter int PHASE_W = 16,
    parameter int ACC_W   = 16,
    parameter int INT_LEN = 1024
) (
    input  logic                  clk,
    input  logic                  rst_in,
    input  logic                  sig,
    input  logic                  sig_en,
    input  logic [PHASE_W-1:0]    code_freq,
    input  logic [PHASE_W-1:0]    tap_spacing,
    input  logic                  phase_load,
    input  logic [PHASE_W-1:0]    phase_init,
    output logic [TAPS*ACC_W-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  overrun
`ifdef CORR_DISC_EN
    ,
    output logic [ACC_W:0]        disc
`endif
);
    localparam int CNT_W = $clog2(INT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INT_LEN - 1);

    typedef enum logic {EMPTY, FULL} ostate_e;

    logic [PHASE_W-1:0]              phase_q, phase_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            accept, dump, restart;
    logic [TAPS-1:0][PHASE_W-1:0]    offset;
    logic [TAPS-1:0][ACC_W-1:0]      sum;
    ostate_e                         state_q, state_d;
    logic [TAPS*ACC_W-1:0]           data_q, data_d;
    logic                            overrun_q, overrun_d;
    logic                            load_out;

    // phase_load wins over a coincident strobe; that sample is dropped.
    assign accept  = sig_en & ~phase_load;
    assign dump    = accept & (cnt_q == CNT_LAST);
    assign restart = phase_load | dump;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        if (phase_load) begin
            phase_d = phase_init;
            cnt_d   = '0;
        end else if (sig_en) begin
            phase_d = phase_q + code_freq;
            cnt_d   = dump ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            phase_q <= '0;
            cnt_q   <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
        end
    end

    genvar k;
    generate
        for (k = 0; k < TAPS; k++) begin : g_tap
            assign offset[k] = PHASE_W'(k) * tap_spacing;

            corr_tap_lane #(
                .PHASE_W(PHASE_W),
                .ACC_W  (ACC_W)
            ) u_lane (
                .clk      (clk),
                .rst_in   (rst_in),
                .phase_i  (phase_q),
                .offset_i (offset[k]),
                .sig_i    (sig),
                .accept_i (accept),
                .restart_i(restart),
                .sum_o    (sum[k])
            );
        end
    endgenerate

    // Output stage: a dump landing while FULL survives only if the old word leaves this edge.
    always_comb begin
        state_d   = state_q;
        overrun_d = overrun_q;
        load_out  = 1'b0;
        case (state_q)
            EMPTY: begin
                if (dump) begin
                    load_out = 1'b1;
                    state_d  = FULL;
                end
            end
            FULL: begin
                if (dump) begin
                    if (out_ready) load_out  = 1'b1;
                    else           overrun_d = 1'b1;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign data_d = load_out ? sum : data_q;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= EMPTY;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = (state_q == FULL);
    assign overrun   = overrun_q;

`ifdef CORR_DISC_EN
    logic [ACC_W:0] disc_q, disc_d;

    // Early minus late, one bit wider so the full +/-2*INT_LEN range fits.
    assign disc_d = load_out ? ({sum[0][ACC_W-1], sum[0]} - {sum[TAPS-1][ACC_W-1], sum[TAPS-1]})
                             : disc_q;

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) disc_q <= '0;
        else        disc_q <= disc_d;
    end

    assign disc = disc_q;
`endif
endmodule

// File: tb/tb_corr_tap_bank.sv
// Directed bench for corr_tap_bank (TAPS=3, INT_LEN=1024); sig is generated from a local phase model.
module tb_corr_tap_bank;
    logic        clk;
    logic        rst_in;
    logic        sig;
    logic        sig_en;
    logic [15:0] code_freq;
    logic [15:0] tap_spacing;
    logic        phase_load;
    logic [15:0] phase_init;
    logic [47:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
`ifdef CORR_DISC_EN
    logic [16:0] disc;
`endif

    int checks = 0;
    int passed = 0;
    logic [15:0] ph;
    bit          inv;

    localparam logic [47:0] ALL_POS = {3{16'h0400}};
    localparam logic [47:0] ALL_NEG = {3{16'hFC00}};
    localparam logic [47:0] SPACED  = {16'h0400, 16'h0000, 16'hFC00};

    corr_tap_bank #(.TAPS(3), .PHASE_W(16), .ACC_W(16), .INT_LEN(1024)) dut (
        .clk        (clk),
        .rst_in     (rst_in),
        .sig        (sig),
        .sig_en     (sig_en),
        .code_freq  (code_freq),
        .tap_spacing(tap_spacing),
        .phase_load (phase_load),
        .phase_init (phase_init),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .overrun    (overrun)
`ifdef CORR_DISC_EN
        ,
        .disc       (disc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle; on idle cycles sig is driven to the wrong value to expose gating faults.
    task automatic step(input bit en);
        sig    = en ? (ph[15] ^ inv) : ~(ph[15] ^ inv);
        sig_en = en;
        @(posedge clk); #1;
        if (en) ph = ph + 16'h0400;
        sig_en = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b1; sig = 1'b0; sig_en = 1'b0; phase_load = 1'b0; phase_init = '0;
        code_freq = 16'h0400; tap_spacing = '0; out_ready = 1'b0; ph = '0; inv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_in = 1'b0;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        checks++; if (out_data !== 48'h0) $display("FAIL reset_data: got %h want 0", out_data); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
`ifdef CORR_DISC_EN
        checks++; if (disc !== 17'h0) $display("FAIL reset_disc: got %h want 0", disc); else passed++;
`endif
    endtask

    task automatic test_basic();
        inv = 1'b0; tap_spacing = '0;
        run(1023);
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_early: valid got %b want 0", out_valid); else passed++;
        run(1);
        checks++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_POS) $display("FAIL basic_data: got %h want %h", out_data, ALL_POS); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b want 0", overrun); else passed++;
        drain();
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: valid got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_spacing();
        inv = 1'b1; tap_spacing = 16'h4000;
        run(1024);
        checks++; if (out_valid !== 1'b1) $display("FAIL spacing_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== SPACED) $display("FAIL spacing_data: got %h want %h", out_data, SPACED); else passed++;
`ifdef CORR_DISC_EN
        checks++; if (disc !== 17'h1F800) $display("FAIL spacing_disc: got %h want 1f800", disc); else passed++;
`endif
        drain();
        tap_spacing = '0;
    endtask

    task automatic test_strobe();
        inv = 1'b0;
        for (int i = 0; i < 1023; i++) begin
            step(1'b1); step(1'b0); step(1'b0);
        end
        checks++; if (out_valid !== 1'b0) $display("FAIL strobe_early: valid got %b want 0", out_valid); else passed++;
        step(1'b1);
        checks++; if (out_valid !== 1'b1) $display("FAIL strobe_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_POS) $display("FAIL strobe_data: got %h want %h", out_data, ALL_POS); else passed++;
        drain();
    endtask

    task automatic test_back_to_back();
        inv = 1'b0;
        run(1024);
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_first_valid: got %b want 1", out_valid); else passed++;
        inv = 1'b1;
        run(1023);
        out_ready = 1'b1;
        step(1'b1);
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_NEG) $display("FAIL b2b_data: got %h want %h", out_data, ALL_NEG); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b want 0", overrun); else passed++;
        drain();
        checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: valid got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_phase_load();
        inv = 1'b0;
        run(500);
        // sig keeps following a reference phase restarted at 0, half a cycle from the loaded 8000.
        phase_init = 16'h8000; phase_load = 1'b1; sig_en = 1'b1; sig = ph[15];
        @(posedge clk); #1;
        phase_load = 1'b0; sig_en = 1'b0; ph = 16'h0000;
        run(1023);
        checks++; if (out_valid !== 1'b0) $display("FAIL load_early: valid got %b want 0", out_valid); else passed++;
        run(1);
        checks++; if (out_valid !== 1'b1) $display("FAIL load_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_NEG) $display("FAIL load_data: got %h want %h", out_data, ALL_NEG); else passed++;
        drain();
        ph = ph ^ 16'h8000;
    endtask

    task automatic test_overrun();
        inv = 1'b0;
        run(1024);
        inv = 1'b1;
        run(1024);
        checks++; if (out_valid !== 1'b1) $display("FAIL ovr_valid: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_POS) $display("FAIL ovr_data: got %h want %h", out_data, ALL_POS); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b want 1", overrun); else passed++;
`ifdef CORR_DISC_EN
        checks++; if (disc !== 17'h0) $display("FAIL ovr_disc: got %h want 0", disc); else passed++;
`endif
        drain();
        checks++; if (out_valid !== 1'b0) $display("FAIL ovr_drain: valid got %b want 0", out_valid); else passed++;
        checks++; if (overrun !== 1'b1) $display("FAIL ovr_sticky: got %b want 1", overrun); else passed++;
    endtask

    task automatic test_reset_mid();
        inv = 1'b0;
        run(500);
        #2 rst_in = 1'b1;
        #1;
        checks++; if (out_data !== 48'h0) $display("FAIL rstmid_data: got %h want 0", out_data); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL rstmid_overrun: got %b want 0", overrun); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else passed++;
        @(posedge clk); #1;
        rst_in = 1'b0; ph = '0;
        run(1023);
        checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_early: valid got %b want 0", out_valid); else passed++;
        run(1);
        checks++; if (out_valid !== 1'b1) $display("FAIL rstmid_valid2: got %b want 1", out_valid); else passed++;
        checks++; if (out_data !== ALL_POS) $display("FAIL rstmid_data2: got %h want %h", out_data, ALL_POS); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_spacing();
        test_strobe();
        test_back_to_back();
        test_phase_load();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
